led_step_scheduler: RTL and testbench
=====================================

# led_step_scheduler

Single-clock scheduler that replaces the ripple divide-by-2 clock chain with clock enables on CLK100MHZ. It sequences the board LEDs through a pattern at a selectable power-of-two step rate, with start/pause/stop control. All logic lives in one clock domain; no derived clocks are generated.

## Interface
- PRESCALE, 50_000_000: base tick period in CLK100MHZ cycles; legal range 2..2^32-1.
- MAX_SEL, 7: largest legal rate_sel; the tap counter is MAX_SEL bits wide.
- CLK100MHZ  input  1  system clock, 100 MHz; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- start  input  1  single-cycle pulse: IDLE→RUN, or PAUSE→RUN.
- stop  input  1  single-cycle pulse: RUN→PAUSE, or PAUSE→IDLE.
- rate_sel  input  3  step period = PRESCALE·2^rate_sel cycles; values above MAX_SEL are clamped to MAX_SEL.
- LED  output  8  pattern register.
- step  output  1  one-cycle strobe, high in the cycle LED takes its new value.
- busy  output  1  high in RUN and PAUSE.

## Operation
- States: IDLE, RUN, PAUSE.
  - IDLE: all counters cleared; LED=0.
  - RUN: counters advance.
  - PAUSE: counters and LED hold.
- Transitions:
  - IDLE + start → RUN; LED loads 8'h01.
  - RUN + stop → PAUSE.
  - PAUSE + start → RUN; resumes with no counter reset.
  - PAUSE + stop → IDLE.
  - start and stop in the same cycle: stop wins.
  - start in RUN and stop in IDLE: ignored.
- Base counter, 32 bits, counts 0..PRESCALE-1 in RUN. base_tick is asserted when the count is PRESCALE-1, and the counter then wraps to 0.
- Tap counter, MAX_SEL bits, increments on base_tick and wraps modulo 2^MAX_SEL.
- step_en is asserted on base_tick when the low sel_q bits of the tap counter are all ones (sel_q=0 gives every base_tick).
- sel_q is the clamped rate_sel. It is captured on entry to RUN from IDLE and in every step_en cycle, so a rate change never truncates the step in progress.
- On step_en, LED rotates left by one, bit 7 wrapping to bit 0 (8'h80→8'h01).

## Timing
- Reset values: state=IDLE, LED=8'h00, step=0, busy=0, all counters 0, sel_q=0.
- RST mid-operation returns everything to the reset values immediately. No step is issued while RST is high.
- Control latency:
  - busy rises one cycle after the start pulse is sampled.
  - The first base_tick occurs PRESCALE cycles after RUN is entered.
  - With sel_q=s, the first LED change occurs PRESCALE·2^s cycles after RUN entry.
- step is the registered step_en, coincident with the LED update. Minimum step spacing is PRESCALE cycles.
- A stop sampled in the same cycle as step_en: the step still completes (LED updates), and the state is PAUSE on the next cycle.
- PAUSE holds cycle-exact position. After resume, the remaining interval to the next step equals the interval that remained at pause time.

## Configuration
- SCHED_BINARY_COUNT_EN:
  - Defined: LED loads 8'h00 on RUN entry and increments by 1 on each step, wrapping 8'hFF→8'h00.
  - Undefined: one-hot rotation as described above.
- All state, timing and step behaviour are identical in both builds.

## Test plan
- Reset: assert RST asynchronously mid-cycle during RUN → LED=0, busy=0, step=0 without waiting for a clock edge; after release, state is IDLE.
- Basic run (PRESCALE=4, rate_sel=0): start → LED=01 next cycle; steps every 4 cycles; LED sequence 02,04,…,80,01; busy=1 throughout.
- Rate and clamp (PRESCALE=4):
  - rate_sel=2 → steps every 16 cycles.
  - Change to 0 mid-interval → the current 16-cycle step completes, then steps every 4 cycles.
  - rate_sel=7 with MAX_SEL=3 → steps every 32 cycles.
- Pause/resume: stop 2 cycles after a step → LED and counters frozen for 20 cycles; start → next step 2 cycles after the resume cycle; second stop from PAUSE → LED=0, busy=0.
- Simultaneous events:
  - start+stop together in RUN → PAUSE.
  - start+stop together in IDLE → stays IDLE.
  - stop coincident with step_en → LED updates, then PAUSE.
- SCHED_BINARY_COUNT_EN build: 257 steps → LED=00, FF, … sequence ending at 8'h01 after wrap; step spacing unchanged.

Source files
------------

// File: rtl/led_step_scheduler.sv
// Steps an 8-bit LED pattern on clock enables derived from CLK100MHZ, with start/pause/stop control.
// Define SCHED_BINARY_COUNT_EN for a binary-count LED pattern instead of one-hot rotation.
module led_step_scheduler #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned MAX_SEL  = 7
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] rate_sel,
  output logic [7:0] LED,
  output logic       step,
  output logic       busy
);

  localparam int unsigned TAP_W     = MAX_SEL;
  localparam logic [31:0] BASE_LAST = 32'(PRESCALE - 1);
`ifdef SCHED_BINARY_COUNT_EN
  localparam logic [7:0] LED_INIT = 8'h00;
`else
  localparam logic [7:0] LED_INIT = 8'h01;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       led_q, led_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;

  logic [2:0]       sel_clamped;
  logic [TAP_W:0]   tap_span;
  logic [TAP_W-1:0] tap_mask;
  logic [7:0]       led_next;
  logic             base_tick;
  logic             step_en;

  assign sel_clamped = (32'(rate_sel) > MAX_SEL) ? 3'(MAX_SEL) : rate_sel;

  // Low sel_q bits of the tap counter select a step every 2^sel_q base ticks.
  assign tap_span  = (TAP_W + 1)'(1) << sel_q;
  assign tap_mask  = TAP_W'(tap_span - (TAP_W + 1)'(1));
  assign base_tick = (state_q == S_RUN) && (base_q == BASE_LAST);
  assign step_en   = base_tick && ((tap_q & tap_mask) == tap_mask);

`ifdef SCHED_BINARY_COUNT_EN
  assign led_next = led_q + 8'd1;
`else
  assign led_next = {led_q[6:0], led_q[7]};
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    tap_d   = tap_q;
    sel_d   = sel_q;
    led_d   = led_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          sel_d   = sel_clamped;
          led_d   = LED_INIT;
        end
      end
      S_RUN: begin
        base_d = base_tick ? 32'd0 : base_q + 32'd1;
        if (base_tick) begin
          tap_d = tap_q + TAP_W'(1);
        end
        // Rate is only re-sampled at a step boundary so an interval is never cut short.
        if (step_en) begin
          sel_d  = sel_clamped;
          led_d  = led_next;
          step_d = 1'b1;
        end
        if (stop) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          base_d  = '0;
          tap_d   = '0;
          sel_d   = '0;
          led_d   = '0;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      tap_q   <= '0;
      sel_q   <= '0;
      led_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tap_q   <= tap_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign LED  = led_q;
  assign step = step_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Bench for led_step_scheduler: vector table, hand-written corner sequences, and a random run
// checked against an elapsed-run-time reference model.
module tb_led_step_scheduler;

  localparam int unsigned P  = 4;
  localparam int unsigned MS = 3;
  localparam int          NV = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [2:0] rate_sel;
  logic [7:0] led;
  logic       step;
  logic       busy;

  int total = 0;
  int bad   = 0;

  led_step_scheduler #(.PRESCALE(P), .MAX_SEL(MS)) dut (
    .CLK100MHZ(clk),
    .RST      (rst),
    .start    (start),
    .stop     (stop),
    .rate_sel (rate_sel),
    .LED      (led),
    .step     (step),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // LED value after n steps since RUN entry; n < 0 means idle.
  function automatic int led_of(input int n);
    if (n < 0) return 0;
`ifdef SCHED_BINARY_COUNT_EN
    return n % 256;
`else
    return 1 << (n % 8);
`endif
  endfunction

  function automatic int clamp_sel(input int r);
    return (r > int'(MS)) ? int'(MS) : r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start    = 1'b0;
    stop     = 1'b0;
    rate_sel = 3'd0;
    rst      = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_step(input string name, input int budget, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!step && cyc < budget);
    if (!step) begin
      total++;
      bad++;
      $display("FAIL %s: got no step want step within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    logic       st;
    logic       sp;
    logic [2:0] rs;
    int         n;
    logic       e_step;
    logic       e_busy;
  } vec_t;

  vec_t vecs [NV];

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;
  mode_t m_mode;
  int    m_run;
  int    m_sel;
  int    m_n;
  logic  m_step;

  // Reference: a step fires whenever accumulated RUN time is a multiple of P*2^sel.
  task automatic model_step(input logic st, input logic sp, input int rs);
    m_step = 1'b0;
    case (m_mode)
      M_IDLE: if (st && !sp) begin
        m_mode = M_RUN;
        m_run  = 0;
        m_sel  = clamp_sel(rs);
        m_n    = 0;
      end
      M_RUN: begin
        m_run++;
        if (m_run % int'(P << m_sel) == 0) begin
          m_step = 1'b1;
          m_n++;
          m_sel = clamp_sel(rs);
        end
        if (sp) m_mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (sp) begin
          m_mode = M_IDLE;
          m_n    = -1;
        end else if (st) begin
          m_mode = M_RUN;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  initial begin
    int  cyc;
    int  hold_led;
    logic held;

    // start, stop, rate, steps-so-far, step, busy
    vecs[0]  = '{1'b0, 1'b1, 3'd0, -1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 3'd0, -1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd0,  0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 3'd0,  0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3'd0,  0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 3'd0,  0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'd0,  1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 3'd0,  1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 3'd0,  1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 3'd0,  1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 3'd0,  1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'd0,  1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3'd0,  1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 3'd0,  2, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 3'd0,  2, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 3'd0, -1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 3'd0, -1, 1'b0, 1'b0};

    do_reset();
    check("reset_led", led, 0);
    check("reset_step", step, 0);
    check("reset_busy", busy, 0);

    for (int i = 0; i < NV; i++) begin
      start    = vecs[i].st;
      stop     = vecs[i].sp;
      rate_sel = vecs[i].rs;
      tick();
      check($sformatf("vec%0d_led", i), led, led_of(vecs[i].n));
      check($sformatf("vec%0d_step", i), step, vecs[i].e_step);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Async reset lands mid-cycle while step is high.
    do_reset();
    pulse_start();
    wait_step("arst_step", 20, cyc);
    #3;
    rst = 1'b1;
    #1;
    check("arst_led", led, 0);
    check("arst_step", step, 0);
    check("arst_busy", busy, 0);
    tick();
    check("arst_hold_step", step, 0);
    rst = 1'b0;
    repeat (6) tick();
    check("arst_idle_busy", busy, 0);
    check("arst_idle_led", led, 0);

    // Rate 2, then drop to 0 mid-interval.
    do_reset();
    rate_sel = 3'd2;
    pulse_start();
    wait_step("rate2_first", 100, cyc);
    check("rate2_first_gap", cyc, 16);
    wait_step("rate2_next", 100, cyc);
    check("rate2_gap", cyc, 16);
    repeat (5) tick();
    rate_sel = 3'd0;
    wait_step("rate_chg", 100, cyc);
    check("rate_chg_remaining", cyc, 11);
    wait_step("rate0_a", 100, cyc);
    check("rate0_gap_a", cyc, 4);
    wait_step("rate0_b", 100, cyc);
    check("rate0_gap_b", cyc, 4);

    // rate_sel 7 clamps to MAX_SEL.
    do_reset();
    rate_sel = 3'd7;
    pulse_start();
    wait_step("clamp_first", 100, cyc);
    check("clamp_first_gap", cyc, 32);
    wait_step("clamp_next", 100, cyc);
    check("clamp_gap", cyc, 32);

    // Pause two cycles after a step, hold, resume.
    do_reset();
    pulse_start();
    wait_step("pause_pre", 20, cyc);
    hold_led = led;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step || led != 8'(hold_led)) held = 1'b0;
    end
    check("pause_frozen", held, 1);
    check("pause_busy", busy, 1);
    pulse_start();
    wait_step("resume", 20, cyc);
    check("resume_gap", cyc, 2);
    check("resume_led", led, led_of(2));
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    check("stop2_led", led, 0);
    check("stop2_busy", busy, 0);

    // Stop coincident with step_en.
    do_reset();
    pulse_start();
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopstep_step", step, 1);
    check("stopstep_led", led, led_of(1));
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (step || led != 8'(led_of(1))) held = 1'b0;
    end
    check("stopstep_paused", held, 1);
    check("stopstep_busy", busy, 1);

    // Long run through pattern wrap.
    do_reset();
    pulse_start();
    check("wrap_init", led, led_of(0));
    for (int i = 1; i <= 257; i++) begin
      wait_step("wrap_step", 10, cyc);
      check($sformatf("wrap_gap%0d", i), cyc, 4);
      check($sformatf("wrap_led%0d", i), led, led_of(i));
    end

    // Random control against the reference model.
    do_reset();
    m_mode = M_IDLE;
    m_run  = 0;
    m_sel  = 0;
    m_n    = -1;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) rate_sel = 3'($urandom_range(0, 7));
      model_step(start, stop, int'(rate_sel));
      tick();
      check("rand_led", led, led_of(m_n));
      check("rand_step", step, m_step);
      check("rand_busy", busy, (m_mode != M_IDLE) ? 1 : 0);
    end
    start = 1'b0;
    stop  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
